// File: rtl/multi_cycle_cpu.sv
// Multi-cycle MIPS-32 core with request/ready instruction and data ports,
// a trap state for unsupported instructions and free-running counters.
// Handshake: a port's request is combinational from the sequencer state.
// Address, write enable and write data hold steady while request is high.
// A transfer completes on the rising edge where request and ready are both 1.
// Request drops in the cycle that follows, and ready while request=0 is ignored.

package multi_cycle_cpu_pkg;
  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4
  } alu_op_t;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_MEMORY    = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_TRAP      = 3'd5
  } state_t;
endpackage

// 32 x 32 register file: two combinational read ports and one write port.
// $0 reads as zero, and writes to it are dropped.
module register_file (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  read_addr_a,
  input  logic [4:0]  read_addr_b,
  output logic [31:0] read_data_a,
  output logic [31:0] read_data_b,
  input  logic        write_enable,
  input  logic [4:0]  write_addr,
  input  logic [31:0] write_data
);
  logic [31:0] regs [0:31];

  // Register storage; cleared on reset, $0 never written
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (write_enable && (write_addr != 5'd0)) begin
      regs[write_addr] <= write_data;
    end
  end

  assign read_data_a = (read_addr_a == 5'd0) ? 32'd0 : regs[read_addr_a];
  assign read_data_b = (read_addr_b == 5'd0) ? 32'd0 : regs[read_addr_b];
endmodule

// Combinational ALU. over flags signed overflow on add/sub.
module alu
  import multi_cycle_cpu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  alu_op_t     op,
  output logic [31:0] result,
  output logic        zero,
  output logic        over
);
  // Operation select and signed-overflow detection
  always_comb begin
    result = '0;
    over   = 1'b0;
    case (op)
      ALU_ADD: begin
        result = a + b;
        over   = (a[31] == b[31]) && (result[31] != a[31]);
      end
      ALU_SUB: begin
        result = a - b;
        over   = (a[31] != b[31]) && (result[31] != a[31]);
      end
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_SLT: result = {31'd0, ($signed(a) < $signed(b))};
      default: result = '0;
    endcase
  end

  assign zero = (result == 32'd0);
endmodule

module multi_cycle_cpu
  import multi_cycle_cpu_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR  = 32'h0000_3000,
  parameter int          COUNTER_WIDTH = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  output logic                     imem_request,
  output logic [31:2]              imem_address,
  input  logic                     imem_ready,
  input  logic [31:0]              imem_instruction,
  output logic                     dmem_request,
  output logic                     dmem_write_enable,
  output logic [31:2]              dmem_address,
  output logic [31:0]              dmem_write_input,
  input  logic                     dmem_ready,
  input  logic [31:0]              dmem_read_result,
  output logic                     halted,
  output logic [COUNTER_WIDTH-1:0] cycle_count,
  output logic [COUNTER_WIDTH-1:0] retired_count,
  output logic [2:0]               debug_state
);
  state_t      state, state_next;
  logic [31:2] pc;
  logic [31:0] ir, a_reg, b_reg, alu_out, mdr;

  // Instruction fields, always taken from the latched IR
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;
  assign opcode = ir[31:26];
  assign rs     = ir[25:21];
  assign rt     = ir[20:16];
  assign rd     = ir[15:11];
  assign funct  = ir[5:0];
  assign imm    = ir[15:0];

  logic is_rtype, is_ori, is_lui, is_lw, is_sw, is_beq, is_j, supported;
  assign is_rtype = (opcode == 6'h00) &&
                    ((funct == 6'h21) || (funct == 6'h23) || (funct == 6'h24) ||
                     (funct == 6'h25) || (funct == 6'h2A));
  assign is_ori   = (opcode == 6'h0D);
  assign is_lui   = (opcode == 6'h0F);
  assign is_lw    = (opcode == 6'h23);
  assign is_sw    = (opcode == 6'h2B);
  assign is_beq   = (opcode == 6'h04);
  assign is_j     = (opcode == 6'h02);
  assign supported = is_rtype | is_ori | is_lui | is_lw | is_sw | is_beq | is_j;

  logic [31:0] sext_imm;
  assign sext_imm = {{16{imm[15]}}, imm};

  // Register file hookup: written only in WRITEBACK
  logic [31:0] rs_data, rt_data, wb_data;
  logic [4:0]  wb_addr;
  logic        wb_enable;
  assign wb_enable = (state == ST_WRITEBACK);
  assign wb_addr   = is_rtype ? rd : rt;
  assign wb_data   = is_lw ? mdr : alu_out;

  register_file u_register_file (
    .clock        (clock),
    .reset        (reset),
    .read_addr_a  (rs),
    .read_addr_b  (rt),
    .read_data_a  (rs_data),
    .read_data_b  (rt_data),
    .write_enable (wb_enable),
    .write_addr   (wb_addr),
    .write_data   (wb_data)
  );

  // ALU operand and operation select; lui is an OR of {imm,16'h0} into zero
  alu_op_t     alu_op;
  logic [31:0] src_a, src_b, alu_result;
  logic        alu_zero, alu_over_unused;
  always_comb begin
    alu_op = ALU_ADD;
    src_a  = a_reg;
    src_b  = sext_imm;
    if (is_rtype) begin
      src_b = b_reg;
      case (funct)
        6'h23:   alu_op = ALU_SUB;
        6'h24:   alu_op = ALU_AND;
        6'h25:   alu_op = ALU_OR;
        6'h2A:   alu_op = ALU_SLT;
        default: alu_op = ALU_ADD;
      endcase
    end else if (is_ori) begin
      alu_op = ALU_OR;
      src_b  = {16'd0, imm};
    end else if (is_lui) begin
      alu_op = ALU_OR;
      src_a  = 32'd0;
      src_b  = {imm, 16'd0};
    end else if (is_beq) begin
      alu_op = ALU_SUB;
      src_b  = b_reg;
    end
  end

  alu u_alu (
    .a      (src_a),
    .b      (src_b),
    .op     (alu_op),
    .result (alu_result),
    .zero   (alu_zero),
    .over   (alu_over_unused)
  );

  // Sequencer state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= ST_FETCH;
    else        state <= state_next;
  end

  // Sequencer next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_FETCH:     if (imem_ready) state_next = ST_DECODE;
      ST_DECODE:    state_next = supported ? ST_EXECUTE : ST_TRAP;
      ST_EXECUTE: begin
        if (is_beq || is_j)     state_next = ST_FETCH;
        else if (is_lw || is_sw) state_next = ST_MEMORY;
        else                    state_next = ST_WRITEBACK;
      end
      ST_MEMORY:    if (dmem_ready) state_next = is_lw ? ST_WRITEBACK : ST_FETCH;
      ST_WRITEBACK: state_next = ST_FETCH;
      ST_TRAP:      state_next = ST_TRAP;
      default:      state_next = ST_FETCH;
    endcase
  end

  // Datapath latches: PC, IR, A, B, ALUOut, MDR
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc      <= RESET_VECTOR[31:2];
      ir      <= '0;
      a_reg   <= '0;
      b_reg   <= '0;
      alu_out <= '0;
      mdr     <= '0;
    end else begin
      case (state)
        ST_FETCH: if (imem_ready) begin
          ir <= imem_instruction;
          pc <= pc + 30'd1;
        end
        ST_DECODE: begin
          a_reg <= rs_data;
          b_reg <= rt_data;
        end
        ST_EXECUTE: begin
          alu_out <= alu_result;
          // pc already points past the branch/jump here
          if (is_beq && alu_zero) pc <= pc + sext_imm[29:0];
          if (is_j)               pc <= {pc[31:28], ir[25:0]};
        end
        ST_MEMORY: if (dmem_ready && is_lw) mdr <= dmem_read_result;
        default: ;
      endcase
    end
  end

  // An instruction retires on the edge leaving its final state
  logic retire;
  always_comb begin
    retire = 1'b0;
    case (state)
      ST_EXECUTE:   retire = is_beq || is_j;
      ST_MEMORY:    retire = is_sw && dmem_ready;
      ST_WRITEBACK: retire = 1'b1;
      default:      retire = 1'b0;
    endcase
  end

  // Performance counters; cycle count stops once trapped
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cycle_count   <= '0;
      retired_count <= '0;
    end else begin
      if (state != ST_TRAP) cycle_count <= cycle_count + COUNTER_WIDTH'(1);
      if (retire)           retired_count <= retired_count + COUNTER_WIDTH'(1);
    end
  end

  // Requests are gated by reset so they fall the instant reset goes low
  assign imem_request      = reset && (state == ST_FETCH);
  assign imem_address      = pc;
  assign dmem_request      = reset && (state == ST_MEMORY);
  assign dmem_write_enable = dmem_request && is_sw;
  assign dmem_address      = alu_out[31:2];
  assign dmem_write_input  = b_reg;
  assign halted            = (state == ST_TRAP);
  assign debug_state       = state;
endmodule

// File: tb/tb_multi_cycle_cpu.sv
// Directed bench for multi_cycle_cpu: small programs in a bench-side
// instruction memory, a data port served by a task with chosen wait states,
// and hand-computed expectations for every observed value.
module tb_multi_cycle_cpu;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        imem_request;
  logic [31:2] imem_address;
  logic        imem_ready = 1'b1;
  logic [31:0] imem_instruction;
  logic        dmem_request;
  logic        dmem_write_enable;
  logic [31:2] dmem_address;
  logic [31:0] dmem_write_input;
  logic        dmem_ready = 1'b0;
  logic [31:0] dmem_read_result = 32'd0;
  logic        halted;
  logic [31:0] cycle_count;
  logic [31:0] retired_count;
  logic [2:0]  debug_state;

  int check_cnt = 0;
  int pass_cnt  = 0;

  logic [31:0] imem_mem [0:63];
  logic [31:0] exp_q[$];
  logic [31:2] exp_addr_q[$];

  // Clock and reset
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d", check_cnt);
    $fatal(1, "watchdog");
  end

  assign imem_instruction = imem_mem[imem_address[7:2]];

  multi_cycle_cpu dut (
    .clock             (clock),
    .reset             (reset),
    .imem_request      (imem_request),
    .imem_address      (imem_address),
    .imem_ready        (imem_ready),
    .imem_instruction  (imem_instruction),
    .dmem_request      (dmem_request),
    .dmem_write_enable (dmem_write_enable),
    .dmem_address      (dmem_address),
    .dmem_write_input  (dmem_write_input),
    .dmem_ready        (dmem_ready),
    .dmem_read_result  (dmem_read_result),
    .halted            (halted),
    .cycle_count       (cycle_count),
    .retired_count     (retired_count),
    .debug_state       (debug_state)
  );

  // Driver tasks
  task automatic load_trap_fill();
    for (int i = 0; i < 64; i++) imem_mem[i] = 32'hFC00_0000;
  endtask

  // Returns at the falling edge right after reset is released
  task automatic do_reset();
    reset = 1'b0;
    dmem_ready = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  // Serves one data access: waits for the request (bounded), records the
  // presented address/enable/data, holds ready low for 'waits' cycles while
  // watching stability, then completes. Returns at the falling edge after
  // the completing rising edge.
  task automatic serve_dmem(input int waits, input logic [31:0] rdata,
                            output logic timed_out, output logic [31:2] addr,
                            output logic we, output logic [31:0] wdata,
                            output logic stable);
    int n;
    n = 0;
    timed_out = 1'b0;
    stable = 1'b1;
    addr = '0;
    we = 1'b0;
    wdata = '0;
    while (dmem_request !== 1'b1 && n < 80) begin
      @(negedge clock);
      n++;
    end
    if (dmem_request !== 1'b1) begin
      timed_out = 1'b1;
      return;
    end
    addr = dmem_address;
    we = dmem_write_enable;
    wdata = dmem_write_input;
    dmem_read_result = rdata;
    for (int i = 0; i < waits; i++) begin
      @(negedge clock);
      if (dmem_request !== 1'b1 || dmem_address !== addr ||
          dmem_write_enable !== we || dmem_write_input !== wdata) stable = 1'b0;
    end
    dmem_ready = 1'b1;
    @(negedge clock);
    dmem_ready = 1'b0;
  endtask

  task automatic test_reset();
    load_trap_fill();
    reset = 1'b0;
    imem_ready = 1'b1;
    repeat (2) @(negedge clock);
    check_cnt++; if (imem_request !== 1'b0) $display("FAIL rst_imem_req: got %b want 0", imem_request); else pass_cnt++;
    check_cnt++; if (dmem_request !== 1'b0) $display("FAIL rst_dmem_req: got %b want 0", dmem_request); else pass_cnt++;
    check_cnt++; if (dmem_write_enable !== 1'b0) $display("FAIL rst_dmem_we: got %b want 0", dmem_write_enable); else pass_cnt++;
    check_cnt++; if (halted !== 1'b0) $display("FAIL rst_halted: got %b want 0", halted); else pass_cnt++;
    check_cnt++; if (cycle_count !== 32'd0) $display("FAIL rst_cycles: got %0d want 0", cycle_count); else pass_cnt++;
    check_cnt++; if (retired_count !== 32'd0) $display("FAIL rst_retired: got %0d want 0", retired_count); else pass_cnt++;
    check_cnt++; if (debug_state !== 3'd0) $display("FAIL rst_state: got %0d want 0", debug_state); else pass_cnt++;
    check_cnt++; if (imem_address !== 30'h0C00) $display("FAIL rst_pc: got %h want 0c00", imem_address); else pass_cnt++;
    reset = 1'b1;
    #1;
    check_cnt++; if (imem_request !== 1'b1) $display("FAIL first_fetch_req: got %b want 1", imem_request); else pass_cnt++;
    check_cnt++; if (imem_address !== 30'h0C00) $display("FAIL first_fetch_addr: got %h want 0c00", imem_address); else pass_cnt++;
  endtask

  // ori/lui/addu, then sw and lw with two wait states each, then sw of the loaded value
  task automatic test_alu_and_memory();
    logic to, we, st;
    logic [31:2] addr;
    logic [31:0] wd;
    load_trap_fill();
    imem_mem[0] = 32'h3401_1234;  // ori  $1,$0,0x1234
    imem_mem[1] = 32'h3C02_ABCD;  // lui  $2,0xABCD
    imem_mem[2] = 32'h0022_1821;  // addu $3,$1,$2
    imem_mem[3] = 32'hAC03_0008;  // sw   $3,8($0)
    imem_mem[4] = 32'h8C04_0008;  // lw   $4,8($0)
    imem_mem[5] = 32'hAC04_000C;  // sw   $4,12($0)
    imem_ready = 1'b1;
    do_reset();
    repeat (12) @(negedge clock);
    check_cnt++; if (retired_count !== 32'd3) $display("FAIL alu_retired: got %0d want 3", retired_count); else pass_cnt++;
    check_cnt++; if (cycle_count !== 32'd12) $display("FAIL alu_cycles: got %0d want 12", cycle_count); else pass_cnt++;

    serve_dmem(2, 32'h0, to, addr, we, wd, st);
    check_cnt++; if (to !== 1'b0) $display("FAIL sw_timeout: got %b want 0", to); else pass_cnt++;
    check_cnt++; if (addr !== 30'h2) $display("FAIL sw_addr: got %h want 2", addr); else pass_cnt++;
    check_cnt++; if (we !== 1'b1) $display("FAIL sw_we: got %b want 1", we); else pass_cnt++;
    check_cnt++; if (wd !== 32'hABCD_1234) $display("FAIL sw_data: got %h want abcd1234", wd); else pass_cnt++;
    check_cnt++; if (st !== 1'b1) $display("FAIL sw_stable: got %b want 1", st); else pass_cnt++;
    check_cnt++; if (dmem_request !== 1'b0) $display("FAIL sw_req_drop: got %b want 0", dmem_request); else pass_cnt++;
    check_cnt++; if (cycle_count !== 32'd18) $display("FAIL sw_cycles: got %0d want 18", cycle_count); else pass_cnt++;
    check_cnt++; if (retired_count !== 32'd4) $display("FAIL sw_retired: got %0d want 4", retired_count); else pass_cnt++;

    serve_dmem(2, 32'hABCD_1234, to, addr, we, wd, st);
    check_cnt++; if (to !== 1'b0) $display("FAIL lw_timeout: got %b want 0", to); else pass_cnt++;
    check_cnt++; if (addr !== 30'h2) $display("FAIL lw_addr: got %h want 2", addr); else pass_cnt++;
    check_cnt++; if (we !== 1'b0) $display("FAIL lw_we: got %b want 0", we); else pass_cnt++;
    check_cnt++; if (st !== 1'b1) $display("FAIL lw_stable: got %b want 1", st); else pass_cnt++;
    check_cnt++; if (retired_count !== 32'd4) $display("FAIL lw_early_retire: got %0d want 4", retired_count); else pass_cnt++;
    @(negedge clock);
    check_cnt++; if (retired_count !== 32'd5) $display("FAIL lw_retired: got %0d want 5", retired_count); else pass_cnt++;
    check_cnt++; if (cycle_count !== 32'd25) $display("FAIL lw_cycles: got %0d want 25 (7 for lw)", cycle_count); else pass_cnt++;

    serve_dmem(0, 32'h0, to, addr, we, wd, st);
    check_cnt++; if (to !== 1'b0) $display("FAIL sw2_timeout: got %b want 0", to); else pass_cnt++;
    check_cnt++; if (addr !== 30'h3) $display("FAIL sw2_addr: got %h want 3", addr); else pass_cnt++;
    check_cnt++; if (wd !== 32'hABCD_1234) $display("FAIL lw_value: got %h want abcd1234", wd); else pass_cnt++;
    check_cnt++; if (retired_count !== 32'd6) $display("FAIL sw2_retired: got %0d want 6", retired_count); else pass_cnt++;
  endtask

  // subu (wrapping), and, or, slt (signed), and a discarded write to $0
  task automatic test_alu_ops();
    logic to, we, st;
    logic [31:2] addr;
    logic [31:0] wd, exp_d;
    logic [31:2] exp_a;
    load_trap_fill();
    imem_mem[0]  = 32'h3401_00F0;  // ori  $1,$0,0x00F0
    imem_mem[1]  = 32'h3402_0FF0;  // ori  $2,$0,0x0FF0
    imem_mem[2]  = 32'h0022_2823;  // subu $5,$1,$2
    imem_mem[3]  = 32'h0022_3024;  // and  $6,$1,$2
    imem_mem[4]  = 32'h0022_3825;  // or   $7,$1,$2
    imem_mem[5]  = 32'h00A1_402A;  // slt  $8,$5,$1
    imem_mem[6]  = 32'hAC05_0000;  // sw   $5,0($0)
    imem_mem[7]  = 32'hAC06_0004;  // sw   $6,4($0)
    imem_mem[8]  = 32'hAC07_0008;  // sw   $7,8($0)
    imem_mem[9]  = 32'hAC08_000C;  // sw   $8,12($0)
    imem_mem[10] = 32'h0022_0021;  // addu $0,$1,$2
    imem_mem[11] = 32'hAC00_0010;  // sw   $0,16($0)
    exp_q = '{32'hFFFF_F100, 32'h0000_00F0, 32'h0000_0FF0, 32'h0000_0001, 32'h0000_0000};
    exp_addr_q = '{30'h0, 30'h1, 30'h2, 30'h3, 30'h4};
    imem_ready = 1'b1;
    do_reset();
    while (exp_q.size() > 0) begin
      exp_d = exp_q.pop_front();
      exp_a = exp_addr_q.pop_front();
      serve_dmem($urandom_range(0, 2), 32'h0, to, addr, we, wd, st);
      check_cnt++; if (to !== 1'b0) $display("FAIL ops_timeout: got %b want 0", to); else pass_cnt++;
      check_cnt++; if (addr !== exp_a || we !== 1'b1) $display("FAIL ops_addr: got %h/%b want %h/1", addr, we, exp_a); else pass_cnt++;
      check_cnt++; if (wd !== exp_d) $display("FAIL ops_data: got %h want %h", wd, exp_d); else pass_cnt++;
      check_cnt++; if (st !== 1'b1) $display("FAIL ops_stable: got %b want 1", st); else pass_cnt++;
    end
  endtask

  // ori, beq not taken, j to 0x3040, j to 0x3010, beq taken onto itself
  task automatic test_branch_jump();
    load_trap_fill();
    imem_mem[0]  = 32'h3401_0001;  // ori $1,$0,1
    imem_mem[1]  = 32'h1020_0005;  // beq $1,$0,+5 (not taken)
    imem_mem[2]  = 32'h0800_0C10;  // j   0x3040
    imem_mem[16] = 32'h0800_0C04;  // j   0x3010
    imem_mem[4]  = 32'h1000_FFFF;  // beq $0,$0,-1 at 0x3010
    imem_ready = 1'b1;
    do_reset();
    repeat (7) @(negedge clock);
    check_cnt++; if (imem_address !== 30'h0C02) $display("FAIL beq_not_taken: got %h want 0c02", imem_address); else pass_cnt++;
    check_cnt++; if (retired_count !== 32'd2) $display("FAIL beq_nt_retired: got %0d want 2", retired_count); else pass_cnt++;
    repeat (2) @(negedge clock);
    check_cnt++; if (retired_count !== 32'd2) $display("FAIL j_early_retire: got %0d want 2", retired_count); else pass_cnt++;
    @(negedge clock);
    check_cnt++; if (imem_address !== 30'h0C10 || imem_request !== 1'b1) $display("FAIL j_target: got %h req %b want 0c10 req 1", imem_address, imem_request); else pass_cnt++;
    check_cnt++; if (retired_count !== 32'd3) $display("FAIL j_retired: got %0d want 3", retired_count); else pass_cnt++;
    repeat (3) @(negedge clock);
    check_cnt++; if (imem_address !== 30'h0C04) $display("FAIL j2_target: got %h want 0c04", imem_address); else pass_cnt++;
    repeat (3) @(negedge clock);
    check_cnt++; if (imem_address !== 30'h0C04 || imem_request !== 1'b1) $display("FAIL beq_taken: got %h req %b want 0c04 req 1", imem_address, imem_request); else pass_cnt++;
    check_cnt++; if (retired_count !== 32'd5) $display("FAIL beq_retired: got %0d want 5", retired_count); else pass_cnt++;
    check_cnt++; if (cycle_count !== 32'd16) $display("FAIL beq_cycles: got %0d want 16", cycle_count); else pass_cnt++;
  endtask

  task automatic test_trap();
    logic saw_req;
    load_trap_fill();
    imem_mem[0] = 32'h3401_0001;  // ori $1,$0,1 ; index 1 holds opcode 6'h3F
    imem_ready = 1'b1;
    do_reset();
    repeat (5) @(negedge clock);
    check_cnt++; if (halted !== 1'b0) $display("FAIL trap_early: got %b want 0", halted); else pass_cnt++;
    @(negedge clock);
    check_cnt++; if (halted !== 1'b1) $display("FAIL trap_halted: got %b want 1", halted); else pass_cnt++;
    saw_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (imem_request !== 1'b0 || dmem_request !== 1'b0) saw_req = 1'b1;
    end
    check_cnt++; if (saw_req !== 1'b0) $display("FAIL trap_requests: got %b want 0", saw_req); else pass_cnt++;
    check_cnt++; if (cycle_count !== 32'd6) $display("FAIL trap_cycles: got %0d want 6", cycle_count); else pass_cnt++;
    check_cnt++; if (retired_count !== 32'd1) $display("FAIL trap_retired: got %0d want 1", retired_count); else pass_cnt++;
    check_cnt++; if (halted !== 1'b1) $display("FAIL trap_absorbing: got %b want 1", halted); else pass_cnt++;
    reset = 1'b0;
    #1;
    check_cnt++; if (halted !== 1'b0 || cycle_count !== 32'd0 || retired_count !== 32'd0) $display("FAIL trap_reset: got h%b c%0d r%0d want h0 c0 r0", halted, cycle_count, retired_count); else pass_cnt++;
  endtask

  task automatic test_abandoned_fetch();
    load_trap_fill();
    imem_mem[0] = 32'h3401_0001;  // ori $1,$0,1
    imem_mem[1] = 32'h3402_0002;  // ori $2,$0,2
    imem_ready = 1'b0;
    do_reset();
    repeat (2) @(negedge clock);
    imem_ready = 1'b1;
    repeat (3) @(negedge clock);
    check_cnt++; if (retired_count !== 32'd0) $display("FAIL iwait_early: got %0d want 0", retired_count); else pass_cnt++;
    @(negedge clock);
    check_cnt++; if (retired_count !== 32'd1 || cycle_count !== 32'd6) $display("FAIL iwait_latency: got r%0d c%0d want r1 c6", retired_count, cycle_count); else pass_cnt++;
    imem_ready = 1'b0;
    repeat (3) @(negedge clock);
    check_cnt++; if (imem_request !== 1'b1 || imem_address !== 30'h0C01) $display("FAIL stall_fetch: got req %b addr %h want req 1 addr 0c01", imem_request, imem_address); else pass_cnt++;
    #3;
    reset = 1'b0;
    #1;
    check_cnt++; if (imem_request !== 1'b0) $display("FAIL abandon_req: got %b want 0", imem_request); else pass_cnt++;
    check_cnt++; if (imem_address !== 30'h0C00) $display("FAIL abandon_pc: got %h want 0c00", imem_address); else pass_cnt++;
    check_cnt++; if (retired_count !== 32'd0 || cycle_count !== 32'd0) $display("FAIL abandon_counters: got r%0d c%0d want 0 0", retired_count, cycle_count); else pass_cnt++;
    imem_ready = 1'b1;
    @(posedge clock);
    #1;
    check_cnt++; if (imem_request !== 1'b0 || imem_address !== 30'h0C00) $display("FAIL ready_in_reset: got req %b addr %h want 0 0c00", imem_request, imem_address); else pass_cnt++;
    @(negedge clock);
    reset = 1'b1;
    #1;
    check_cnt++; if (imem_request !== 1'b1 || imem_address !== 30'h0C00) $display("FAIL refetch: got req %b addr %h want 1 0c00", imem_request, imem_address); else pass_cnt++;
  endtask

  // Sequencing and final report
  initial begin
    test_reset();
    test_alu_and_memory();
    test_alu_ops();
    test_branch_jump();
    test_trap();
    test_abandoned_fetch();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end
endmodule
